// File: rtl/spi_xfer_master.sv
// SPI master, CPOL=0, LSB first, 0..32 bits per command, sck half-period of DIV clocks.
// A valid/ready command port starts a transfer; a valid/ready response port returns the MISO bits.
module spi_xfer_master #(
    parameter int DIV = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [5:0]  i_cmd_len,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_ss,
    output logic        o_sck,
    output logic        o_mosi,
    input  logic        i_miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [31:0]   r_tx, w_tx;
    logic [31:0]   r_rx, w_rx;
    logic [5:0]    r_len, w_len;
    logic [4:0]    r_bit_idx, w_bit_idx;
    logic          r_hold_second, w_hold_second;
    logic          r_cmd_ready, w_cmd_ready;
    logic          r_rsp_valid, w_rsp_valid;
    logic [31:0]   r_rsp_data, w_rsp_data;
    logic          r_ss, w_ss;
    logic          r_sck, w_sck;
    logic          r_mosi, w_mosi;

    logic          w_phase_end;
    logic          w_last_bit;
    logic [5:0]    w_eff_len;

    assign w_phase_end = (r_cnt == CNT_LAST);
    assign w_last_bit  = ({1'b0, r_bit_idx} == (r_len - 6'd1));
    assign w_eff_len   = (i_cmd_len > 6'd32) ? 6'd32 : i_cmd_len;

    // NOTE: every next-value signal takes its current value first, so no path leaves one unassigned.
    always_comb begin
        w_state       = r_state;
        w_tx          = r_tx;
        w_rx          = r_rx;
        w_len         = r_len;
        w_bit_idx     = r_bit_idx;
        w_hold_second = r_hold_second;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_data    = r_rsp_data;
        w_ss          = r_ss;
        w_sck         = r_sck;
        w_mosi        = r_mosi;
        w_cnt         = (r_state == S_IDLE || r_state == S_DONE || w_phase_end) ? '0 : r_cnt + CW'(1);

        unique case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_tx          = i_cmd_data;
                    w_len         = w_eff_len;
                    w_rx          = '0;
                    w_bit_idx     = '0;
                    w_hold_second = 1'b0;
                    if (w_eff_len == 6'd0) begin
                        // Empty transfer: one cycle through HOLD with ss left high.
                        w_state = S_HOLD;
                    end else begin
                        w_state = S_SETUP;
                        w_ss    = 1'b0;
                        w_mosi  = i_cmd_data[0];
                        w_sck   = 1'b0;
                    end
                end
            end
            S_SETUP, S_LOW: begin
                if (w_phase_end) begin
                    w_state = S_HIGH;
                    w_sck   = 1'b1;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_rx[r_bit_idx] = i_miso;
                    w_sck           = 1'b0;
                    if (w_last_bit) begin
                        w_state = S_HOLD;
                        w_mosi  = 1'b0;
                    end else begin
                        w_state   = S_LOW;
                        w_mosi    = r_tx[r_bit_idx + 5'd1];
                        w_bit_idx = r_bit_idx + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                // Trailing sck-low phase followed by the ss hold phase: two DIV periods.
                if (r_len == 6'd0) begin
                    w_state     = S_DONE;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = '0;
                end else if (w_phase_end) begin
                    if (r_hold_second) begin
                        w_state     = S_DONE;
                        w_ss        = 1'b1;
                        w_rsp_valid = 1'b1;
                        w_rsp_data  = r_rx;
                    end else begin
                        w_hold_second = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_cmd_ready = (w_state == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset branch is synchronous.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_len         <= '0;
            r_bit_idx     <= '0;
            r_hold_second <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_ss          <= 1'b1;
            r_sck         <= 1'b0;
            r_mosi        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_tx          <= w_tx;
            r_rx          <= w_rx;
            r_len         <= w_len;
            r_bit_idx     <= w_bit_idx;
            r_hold_second <= w_hold_second;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_data    <= w_rsp_data;
            r_ss          <= w_ss;
            r_sck         <= w_sck;
            r_mosi        <= w_mosi;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_ss        = r_ss;
    assign o_sck       = r_sck;
    assign o_mosi      = r_mosi;

endmodule

// File: tb/tb_spi_xfer_master.sv
// Bench for spi_xfer_master: three instances (DIV=1,2,3), table vectors, hand-written corner
// sequences and random transfers checked against a word-level model of the serial link.
module tb_spi_xfer_master;

    localparam int NDUT = 3;
    localparam int BUDGET = 400;

    // miso modes: loopback, tied high, tied low, inverted loopback
    localparam int M_LOOP = 0;
    localparam int M_ONE  = 1;
    localparam int M_ZERO = 2;
    localparam int M_INV  = 3;

    logic        clk;
    logic        reset;
    logic        cmd_valid [NDUT];
    logic        cmd_ready [NDUT];
    logic [5:0]  cmd_len   [NDUT];
    logic [31:0] cmd_data  [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_data  [NDUT];
    logic        ss        [NDUT];
    logic        sck       [NDUT];
    logic        mosi      [NDUT];
    logic        miso      [NDUT];
    int          miso_mode [NDUT];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign miso[g] = (miso_mode[g] == M_LOOP) ? mosi[g] :
                         (miso_mode[g] == M_ONE)  ? 1'b1 :
                         (miso_mode[g] == M_ZERO) ? 1'b0 : ~mosi[g];

        spi_xfer_master #(.DIV(g + 1)) u_dut (
            .i_clock     (clk),
            .i_reset     (reset),
            .i_cmd_valid (cmd_valid[g]),
            .o_cmd_ready (cmd_ready[g]),
            .i_cmd_len   (cmd_len[g]),
            .i_cmd_data  (cmd_data[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_data  (rsp_data[g]),
            .o_ss        (ss[g]),
            .o_sck       (sck[g]),
            .o_mosi      (mosi[g]),
            .i_miso      (miso[g])
        );
    end

    typedef struct {
        int          dut;
        logic [5:0]  len;
        logic [31:0] data;
        int          mode;
        logic [31:0] exp_rsp;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Word-level model: the slave sees the low len bits of data, LSB first, and answers per mode.
    function automatic logic [31:0] ref_rsp(input int len, input logic [31:0] data, input int mode);
        int          n;
        logic [31:0] mask;
        n    = (len > 32) ? 32 : len;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        case (mode)
            M_LOOP:  return data & mask;
            M_ONE:   return mask;
            M_ZERO:  return 32'h0;
            default: return ~data & mask;
        endcase
    endfunction

    function automatic int ref_lat(input int len, input int div);
        int n;
        n = (len > 32) ? 32 : len;
        return (n == 0) ? 1 : (2 * n + 2) * div;
    endfunction

    // Issues one command and watches the link until rsp_valid, one sample per cycle on negedge.
    // n counts clock edges since the accept edge.
    task automatic run_xfer(input int d, input logic [5:0] len, input logic [31:0] data,
                            input int mode, output logic [31:0] rsp, output int lat,
                            output int pulses, output int ss_low, output int bad_runs,
                            output bit mosi_hi);
        int   div;
        int   hi_run;
        int   lo_run;
        logic prev;
        div = d + 1;
        rsp = '0; lat = -1; pulses = 0; ss_low = 0; bad_runs = 0; mosi_hi = 1'b0;
        hi_run = 0; lo_run = 0; prev = 1'b0;
        @(negedge clk);
        miso_mode[d] = mode;
        cmd_len[d]   = len;
        cmd_data[d]  = data;
        cmd_valid[d] = 1'b1;
        check($sformatf("d%0d_cmd_ready_before_accept", d), 64'(cmd_ready[d]), 64'd1);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (n > 0) @(negedge clk);
            if (rsp_valid[d]) begin
                lat = n;
                rsp = rsp_data[d];
                break;
            end
            if (!ss[d]) ss_low++;
            if (mosi[d]) mosi_hi = 1'b1;
            if (sck[d] && !prev) begin
                if (pulses == 0 && n != div) bad_runs++;
                if (pulses > 0 && lo_run != div) bad_runs++;
                pulses++;
                hi_run = 0;
            end
            if (!sck[d] && prev) begin
                if (hi_run != div) bad_runs++;
                lo_run = 0;
            end
            if (sck[d]) hi_run++;
            else lo_run++;
            prev = sck[d];
        end
    endtask

    task automatic do_vec(input string tag, input int d, input logic [5:0] len,
                          input logic [31:0] data, input int mode, input logic [31:0] exp_rsp,
                          input int exp_lat, input int exp_pulses);
        logic [31:0] rsp;
        int          lat, pulses, ss_low, bad_runs;
        bit          mosi_hi;
        run_xfer(d, len, data, mode, rsp, lat, pulses, ss_low, bad_runs, mosi_hi);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rsp_data"}, 64'(rsp), 64'(exp_rsp));
        check({tag, "_sck_pulses"}, 64'(pulses), 64'(exp_pulses));
        check({tag, "_ss_low_cycles"}, 64'(ss_low), 64'((exp_pulses == 0) ? 0 : exp_lat));
        check({tag, "_sck_phase_errors"}, 64'(bad_runs), 64'd0);
        if (data == 32'h0) check({tag, "_mosi_quiet"}, 64'(mosi_hi), 64'd0);
        @(negedge clk);
        check({tag, "_after_handshake"}, {62'd0, rsp_valid[d], cmd_ready[d]}, 64'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rsp;
        int          lat, pulses, ss_low, bad_runs;
        bit          mosi_hi;

        vecs[0] = '{0, 6'd8,  32'h0000_00A5, M_LOOP, 32'h0000_00A5, 18,  8};
        vecs[1] = '{1, 6'd5,  32'h0000_0000, M_ONE,  32'h0000_001F, 24,  5};
        vecs[2] = '{2, 6'd32, 32'hDEAD_BEEF, M_LOOP, 32'hDEAD_BEEF, 198, 32};
        vecs[3] = '{0, 6'd0,  32'hFFFF_FFFF, M_ONE,  32'h0000_0000, 1,   0};
        vecs[4] = '{0, 6'd40, 32'h1234_5678, M_LOOP, 32'h1234_5678, 66,  32};
        vecs[5] = '{1, 6'd12, 32'hFFFF_F0F0, M_INV,  32'h0000_0F0F, 52,  12};
        vecs[6] = '{2, 6'd1,  32'h0000_0001, M_ZERO, 32'h0000_0000, 12,  1};

        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_len[d]   = '0;
            cmd_data[d]  = '0;
            rsp_ready[d] = 1'b1;
            miso_mode[d] = M_LOOP;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_reset_ctrl", d),
                  {59'd0, ss[d], sck[d], mosi[d], rsp_valid[d], cmd_ready[d]}, 64'b10001);
            check($sformatf("d%0d_reset_rsp_data", d), 64'(rsp_data[d]), 64'd0);
        end

        for (int i = 0; i < 7; i++)
            do_vec($sformatf("vec%0d", i), vecs[i].dut, vecs[i].len, vecs[i].data, vecs[i].mode,
                   vecs[i].exp_rsp, vecs[i].exp_lat, vecs[i].exp_pulses);

        // Back-pressure: hold rsp_ready low, offer a competing command that must be ignored.
        rsp_ready[1] = 1'b0;
        run_xfer(1, 6'd6, 32'h0000_002D, M_LOOP, rsp, lat, pulses, ss_low, bad_runs, mosi_hi);
        check("bp_latency", 64'(lat), 64'd28);
        cmd_len[1]   = 6'd6;
        cmd_data[1]  = 32'h0000_003F;
        cmd_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_c%0d", i),
                  {29'd0, rsp_valid[1], cmd_ready[1], ss[1], rsp_data[1]},
                  {29'd0, 1'b1, 1'b0, 1'b1, 32'h0000_002D});
        end
        cmd_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release", {61'd0, rsp_valid[1], cmd_ready[1], ss[1]}, 64'b011);
        do_vec("bp_next", 1, 6'd7, 32'h0000_0055, M_LOOP, 32'h0000_0055, 32, 7);

        // Reset during bit 3 of a len=8 transfer on the DIV=1 instance.
        @(negedge clk);
        miso_mode[0] = M_LOOP;
        cmd_len[0]   = 6'd8;
        cmd_data[0]  = 32'h0000_00FF;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("midreset_bit3_high", {62'd0, ss[0], sck[0]}, 64'b01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ctrl", {59'd0, ss[0], sck[0], mosi[0], rsp_valid[0], cmd_ready[0]},
              64'b10001);
        check("midreset_rsp_data", 64'(rsp_data[0]), 64'd0);
        do_vec("post_reset", 0, 6'd8, 32'h0000_003C, M_LOOP, 32'h0000_003C, 18, 8);

        // Reset and command in the same cycle: the command must not be taken.
        reset        = 1'b1;
        cmd_len[2]   = 6'd4;
        cmd_data[2]  = 32'h0000_000F;
        cmd_valid[2] = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        cmd_valid[2] = 1'b0;
        check("rst_cmd_same_cycle", {62'd0, ss[2], cmd_ready[2]}, 64'b11);
        repeat (2) @(negedge clk);
        check("rst_cmd_not_started", {61'd0, ss[2], sck[2], cmd_ready[2]}, 64'b101);

        for (int i = 0; i < 24; i++) begin
            int          d, mode, len_i;
            logic [31:0] data;
            d     = int'($urandom_range(0, NDUT - 1));
            mode  = int'($urandom_range(0, 3));
            len_i = int'($urandom_range(0, 40));
            data  = $urandom;
            do_vec($sformatf("rnd%0d", i), d, 6'(len_i), data, mode, ref_rsp(len_i, data, mode),
                   ref_lat(len_i, d + 1), (len_i > 32) ? 32 : len_i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
